// File: rtl/training_loader.sv
// Training-sample loader for the KNN distance calculator: one M*N-element sample per data_request edge.
// Optional shadow prefetch buffer enabled by defining TRAIN_LOADER_PREFETCH_EN.
module training_loader #(
   parameter int M            = 4,
   parameter int N            = 4,
   parameter int W            = 8,
   parameter int TYPE_W       = 4,
   parameter int MAX_ELEMENTS = 64,
   parameter int ADDR_W       = 16,
   localparam int CNT_W       = $clog2(MAX_ELEMENTS + 1),
   localparam int TA_W        = $clog2(MAX_ELEMENTS),
   localparam int E           = M * N
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CNT_W-1:0]      num_samples,
   input  logic                  data_request,
   output logic                  mem_rd_en,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [W-1:0]          mem_rdata,
   output logic                  type_rd_en,
   output logic [TA_W-1:0]       type_addr,
   input  logic [TYPE_W-1:0]     type_rdata,
   output logic [E-1:0][W-1:0]   training_data,
   output logic [TYPE_W-1:0]     training_data_type,
   output logic                  read_done,
   output logic [CNT_W-1:0]      sample_idx,
   output logic                  all_loaded
);

   localparam int CW = $clog2(E + 1);
   localparam int PW = ADDR_W + CNT_W;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ELEMENTS);
   localparam logic [CW-1:0]    LAST    = CW'(E);

   typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

   state_t                 state_q, state_d;
   logic                   req_q, req_rise;
   logic [CNT_W-1:0]       cnt_q, cnt_d, idx_q, idx_d, idx_nx, clamp_cnt;
   logic                   all_q, all_d;
   logic [ADDR_W-1:0]      base_q, base_d;
   logic [CW-1:0]          c_q, c_d;
   logic [E-1:0][W-1:0]    data_q, data_d;
   logic [TYPE_W-1:0]      type_q, type_d;

`ifdef TRAIN_LOADER_PREFETCH_EN
   logic [E-1:0][W-1:0]    shd_data_q, shd_data_d;
   logic [TYPE_W-1:0]      shd_type_q, shd_type_d;
   logic                   shd_vld_q, shd_vld_d;
   logic                   pend_q, pend_d;
   logic                   rd_q, rd_d;
`endif

   // Sample base address, truncated to the memory address width.
   function automatic logic [ADDR_W-1:0] base_of(input logic [CNT_W-1:0] idx);
      logic [PW-1:0] prod;
      prod = PW'(idx) * PW'(E);
      return prod[ADDR_W-1:0];
   endfunction

   assign req_rise  = data_request & ~req_q;
   assign idx_nx    = idx_q + CNT_W'(1);
   assign clamp_cnt = (num_samples > MAX_CNT) ? MAX_CNT : num_samples;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      all_d      = all_q;
      base_d     = base_q;
      c_d        = c_q;
      data_d     = data_q;
      type_d     = type_q;
      mem_rd_en  = 1'b0;
      mem_addr   = '0;
      type_rd_en = 1'b0;
      type_addr  = '0;
      read_done  = 1'b0;
`ifdef TRAIN_LOADER_PREFETCH_EN
      shd_data_d = shd_data_q;
      shd_type_d = shd_type_q;
      shd_vld_d  = shd_vld_q;
      pend_d     = pend_q;
      rd_d       = 1'b0;
      read_done  = rd_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               idx_d = '0;
               all_d = 1'b0;
               cnt_d = clamp_cnt;
`ifdef TRAIN_LOADER_PREFETCH_EN
               shd_vld_d = 1'b0;
               pend_d    = 1'b0;
               if (clamp_cnt != '0) begin
                  state_d = FETCH;
                  c_d     = '0;
                  base_d  = '0;
               end
`endif
            end
`ifdef TRAIN_LOADER_PREFETCH_EN
            // Serve from the shadow and immediately prefetch the following sample.
            else if ((req_rise || pend_q) && shd_vld_q) begin
               data_d    = shd_data_q;
               type_d    = shd_type_q;
               rd_d      = 1'b1;
               idx_d     = idx_nx;
               shd_vld_d = 1'b0;
               pend_d    = 1'b0;
               if (idx_nx < cnt_q) begin
                  state_d = FETCH;
                  c_d     = '0;
                  base_d  = base_of(idx_nx);
               end
            end
`endif
            else if (req_rise) begin
               if (idx_q < cnt_q) begin
                  state_d = FETCH;
                  c_d     = '0;
                  base_d  = base_of(idx_q);
`ifdef TRAIN_LOADER_PREFETCH_EN
                  pend_d  = 1'b1;
`endif
               end else begin
                  all_d = 1'b1;
               end
            end
         end

         FETCH: begin
            if (c_q < LAST) begin
               mem_rd_en = 1'b1;
               mem_addr  = base_q + ADDR_W'(c_q);
            end
            if (c_q == '0) begin
               type_rd_en = 1'b1;
               type_addr  = TA_W'(idx_q);
            end
            // Read data lags the strobe by one cycle, so counter value j+1 carries element j.
`ifdef TRAIN_LOADER_PREFETCH_EN
            for (int unsigned j = 0; j < E; j++)
               if (c_q == CW'(j + 1)) shd_data_d[j] = mem_rdata;
            if (c_q == CW'(1)) shd_type_d = type_rdata;
            if (req_rise && (idx_q < cnt_q)) pend_d = 1'b1;
`else
            for (int unsigned j = 0; j < E; j++)
               if (c_q == CW'(j + 1)) data_d[j] = mem_rdata;
            if (c_q == CW'(1)) type_d = type_rdata;
`endif
            if (c_q == LAST) begin
`ifdef TRAIN_LOADER_PREFETCH_EN
               state_d   = IDLE;
               shd_vld_d = 1'b1;
`else
               state_d   = DONE;
`endif
            end else begin
               c_d = c_q + CW'(1);
            end
         end

         DONE: begin
            read_done = 1'b1;
            if (idx_q < cnt_q) idx_d = idx_nx;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         all_q   <= 1'b0;
         base_q  <= '0;
         c_q     <= '0;
         data_q  <= '0;
         type_q  <= '0;
`ifdef TRAIN_LOADER_PREFETCH_EN
         shd_data_q <= '0;
         shd_type_q <= '0;
         shd_vld_q  <= 1'b0;
         pend_q     <= 1'b0;
         rd_q       <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= data_request;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         all_q   <= all_d;
         base_q  <= base_d;
         c_q     <= c_d;
         data_q  <= data_d;
         type_q  <= type_d;
`ifdef TRAIN_LOADER_PREFETCH_EN
         shd_data_q <= shd_data_d;
         shd_type_q <= shd_type_d;
         shd_vld_q  <= shd_vld_d;
         pend_q     <= pend_d;
         rd_q       <= rd_d;
`endif
      end
   end

   assign training_data      = data_q;
   assign training_data_type = type_q;
   assign sample_idx         = idx_q;
   assign all_loaded         = all_q;

endmodule

// File: tb/tb_training_loader.sv
// Scoreboard bench for training_loader: expected memory reads and deliveries are queued by a
// request-level model; a negedge monitor pops and compares them as the DUT produces them.
module tb_training_loader;
   localparam int M = 2, N = 2, W = 8, TYPE_W = 4, MAX_ELEMENTS = 8, ADDR_W = 8;
   localparam int E     = M * N;
   localparam int CNT_W = $clog2(MAX_ELEMENTS + 1);
   localparam int TA_W  = $clog2(MAX_ELEMENTS);
   localparam int MEMSZ = 1 << ADDR_W;

   logic                 clk = 1'b0;
   logic                 rst, start, data_request;
   logic [CNT_W-1:0]     num_samples;
   logic                 mem_rd_en, type_rd_en, read_done, all_loaded;
   logic [ADDR_W-1:0]    mem_addr;
   logic [TA_W-1:0]      type_addr;
   logic [W-1:0]         mem_rdata = '0;
   logic [TYPE_W-1:0]    type_rdata = '0;
   logic [E-1:0][W-1:0]  training_data;
   logic [TYPE_W-1:0]    training_data_type;
   logic [CNT_W-1:0]     sample_idx;

   logic [W-1:0]         mem  [MEMSZ];
   logic [TYPE_W-1:0]    tmem [MAX_ELEMENTS];

   int checks = 0, errors = 0, n = 0;

   typedef struct { logic [63:0] vec; logic [TYPE_W-1:0] typ; int idx; int cyc; } resp_t;
   typedef struct { int addr; int cyc; } rd_t;
   resp_t exp_resp[$];
   rd_t   exp_mem[$];
   rd_t   exp_type[$];

   training_loader #(.M(M), .N(N), .W(W), .TYPE_W(TYPE_W),
                     .MAX_ELEMENTS(MAX_ELEMENTS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .data_request(data_request), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .type_rd_en(type_rd_en), .type_addr(type_addr),
      .type_rdata(type_rdata), .training_data(training_data),
      .training_data_type(training_data_type), .read_done(read_done),
      .sample_idx(sample_idx), .all_loaded(all_loaded));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en)  mem_rdata  <= mem[mem_addr];
      if (type_rd_en) type_rdata <= tmem[type_addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
      end
   endtask

   function automatic logic [63:0] sample_vec(input int s);
      logic [63:0] v;
      v = '0;
      for (int j = 0; j < E; j++) v[j*W +: W] = mem[(s*E + j) % MEMSZ];
      return v;
   endfunction

   task automatic expect_reads(input int s, input int first_cyc);
      for (int j = 0; j < E; j++) exp_mem.push_back('{addr: (s*E + j) % MEMSZ, cyc: first_cyc + j});
      exp_type.push_back('{addr: s, cyc: first_cyc});
   endtask

   task automatic expect_resp(input int s, input int cyc, input int idx_seen);
      exp_resp.push_back('{vec: sample_vec(s), typ: tmem[s], idx: idx_seen, cyc: cyc});
   endtask

   rd_t         me, te;
   resp_t       re;
   logic [63:0] act_vec;
   always @(negedge clk) begin
      if (mem_rd_en) begin
         if (exp_mem.size() == 0) chk("mem_rd_en_unexpected", 64'(mem_rd_en), 0);
         else begin
            me = exp_mem.pop_front();
            chk("mem_addr", 64'(mem_addr), 64'(me.addr));
            chk("mem_rd_cycle", 64'(n), 64'(me.cyc));
         end
      end
      if (type_rd_en) begin
         if (exp_type.size() == 0) chk("type_rd_en_unexpected", 64'(type_rd_en), 0);
         else begin
            te = exp_type.pop_front();
            chk("type_addr", 64'(type_addr), 64'(te.addr));
            chk("type_rd_cycle", 64'(n), 64'(te.cyc));
         end
      end
      if (read_done) begin
         if (exp_resp.size() == 0) chk("read_done_unexpected", 64'(read_done), 0);
         else begin
            re = exp_resp.pop_front();
            act_vec = '0;
            for (int j = 0; j < E; j++) act_vec[j*W +: W] = training_data[j];
            chk("training_data", act_vec, re.vec);
            chk("training_data_type", 64'(training_data_type), 64'(re.typ));
            chk("sample_idx_at_done", 64'(sample_idx), 64'(re.idx));
            chk("read_done_cycle", 64'(n), 64'(re.cyc));
         end
      end
   end

   task automatic drive_raw(input bit req, input bit st, input int ns, input bit r);
      rst = r; data_request = req; start = st; num_samples = CNT_W'(ns);
      @(posedge clk); #1;
      n++;
   endtask

   task automatic check_reset_vals();
      chk("rst_mem_rd_en", 64'(mem_rd_en), 0);
      chk("rst_mem_addr", 64'(mem_addr), 0);
      chk("rst_type_rd_en", 64'(type_rd_en), 0);
      chk("rst_type_addr", 64'(type_addr), 0);
      chk("rst_training_data", 64'(training_data), 0);
      chk("rst_training_type", 64'(training_data_type), 0);
      chk("rst_read_done", 64'(read_done), 0);
      chk("rst_sample_idx", 64'(sample_idx), 0);
      chk("rst_all_loaded", 64'(all_loaded), 0);
   endtask

   task automatic load_default_mem();
      for (int k = 0; k < MEMSZ; k++) mem[k] = W'(k + 1);
      for (int s = 0; s < MAX_ELEMENTS; s++) tmem[s] = TYPE_W'(s + 5);
   endtask

   task automatic final_drain_checks();
      chk("missing_read_done", 64'(exp_resp.size()), 0);
      chk("missing_mem_reads", 64'(exp_mem.size()), 0);
      chk("missing_type_reads", 64'(exp_type.size()), 0);
   endtask

`ifdef TRAIN_LOADER_PREFETCH_EN
   int s0, r0, r1, s1;
   initial begin
      load_default_mem();
      drive_raw(0, 0, 0, 1);
      drive_raw(0, 0, 0, 1);
      check_reset_vals();
      s0 = n; expect_reads(0, s0 + 1);
      drive_raw(0, 1, 2, 0);
      repeat (20) drive_raw(0, 0, 2, 0);
      r0 = n; expect_resp(0, r0 + 1, 1); expect_reads(1, r0 + 1);
      drive_raw(1, 0, 2, 0);
      r1 = r0 + 11;
      while (n < r1) drive_raw(0, 0, 2, 0);
      expect_resp(1, r1 + 1, 2);
      drive_raw(1, 0, 2, 0);
      repeat (20) drive_raw(0, 0, 2, 0);
      drive_raw(1, 0, 2, 0);
      drive_raw(0, 0, 2, 0);
      chk("pf_all_loaded", 64'(all_loaded), 1);
      s1 = n; expect_reads(0, s1 + 1);
      drive_raw(0, 1, 2, 0);
      drive_raw(0, 0, 2, 0);
      expect_resp(0, s1 + E + 3, 1); expect_reads(1, s1 + E + 3);
      drive_raw(1, 0, 2, 0);
      repeat (20) drive_raw(0, 0, 2, 0);
      chk("pf_all_loaded_cleared", 64'(all_loaded), 0);
      final_drain_checks();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
`else
   // Request-level model: a rising request accepted while idle occupies E+3 cycles.
   int m_idx = 0, m_cnt = 0, ready_n = 0;
   bit m_all = 1'b0, prev_req = 1'b0;

   task automatic drive(input bit req, input bit st, input int ns, input bit r);
      bit rise;
      rise = req && !prev_req;
      prev_req = req;
      if (!r && n >= ready_n) begin
         chk("sample_idx", 64'(sample_idx), 64'(m_idx));
         chk("all_loaded", 64'(all_loaded), 64'(m_all));
         if (st) begin
            m_idx = 0; m_all = 1'b0;
            m_cnt = (ns > MAX_ELEMENTS) ? MAX_ELEMENTS : ns;
         end else if (rise) begin
            if (m_idx < m_cnt) begin
               expect_reads(m_idx, n + 1);
               expect_resp(m_idx, n + E + 2, m_idx);
               m_idx++;
               ready_n = n + E + 3;
            end else begin
               m_all = 1'b1;
            end
         end
      end
      drive_raw(req, st, ns, r);
      if (r) begin
         exp_mem.delete(); exp_type.delete(); exp_resp.delete();
         m_idx = 0; m_cnt = 0; m_all = 1'b0; prev_req = 1'b0; ready_n = n;
      end
   endtask

   task automatic pulse_req(input int hold, input int gap);
      repeat (hold) drive(1, 0, 0, 0);
      repeat (gap) drive(0, 0, 0, 0);
   endtask

   bit rq, rs, rr;
   initial begin
      load_default_mem();
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      check_reset_vals();
      drive(0, 1, 3, 0);
      drive(0, 0, 3, 0);
      repeat (4) pulse_req(2, 8);
      chk("all_loaded_after_exhaust", 64'(all_loaded), 1);
      drive(0, 1, 3, 0);
      pulse_req(20, 8);
      drive(0, 1, 3, 0);
      drive(0, 0, 3, 0);
      drive(1, 0, 3, 0);
      drive(1, 0, 3, 0);
      drive(1, 0, 3, 0);
      drive(1, 0, 3, 1);
      drive(0, 0, 3, 1);
      check_reset_vals();
      drive(0, 1, 3, 0);
      pulse_req(1, 8);
      drive(1, 1, 0, 0);
      repeat (3) drive(0, 0, 0, 0);
      pulse_req(1, 4);
      chk("all_loaded_zero_samples", 64'(all_loaded), 1);
      drive(1, 1, 3, 0);
      repeat (4) drive(1, 0, 0, 0);
      repeat (4) drive(0, 0, 0, 0);
      pulse_req(1, 8);
      drive(0, 1, 15, 0);
      repeat (10) pulse_req(1, 6);
      chk("clamped_sample_idx", 64'(sample_idx), 64'(MAX_ELEMENTS));
      for (int k = 0; k < MEMSZ; k++) mem[k] = W'($urandom);
      for (int s = 0; s < MAX_ELEMENTS; s++) tmem[s] = TYPE_W'($urandom);
      drive(0, 1, 6, 0);
      for (int i = 0; i < 600; i++) begin
         rq = ($urandom_range(0, 3) == 0) ? !prev_req : prev_req;
         rs = ($urandom_range(0, 49) == 0);
         rr = ($urandom_range(0, 299) == 0);
         drive(rq, rs, $urandom_range(0, 12), rr);
      end
      repeat (E + 4) drive(0, 0, 0, 0);
      final_drain_checks();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (checks %0d, errors %0d)", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/training_loader.md
Name: training_loader

Overview:
- Upstream feeder for the distance calculator in the KNN system.
- On each `data_request` from the calculator, it fetches the next training sample (M*N elements of W bits, plus its type) from a synchronous sample memory.
- It presents the sample as a stable parallel vector and pulses `read_done`.
- It tracks how many samples have been delivered and flags when the training set is exhausted.

Parameters:
- M, 4, sample rows
- N, 4, sample columns
- W, 8, element width in bits
- TYPE_W, 4, class/type label width
- MAX_ELEMENTS, 64, maximum number of training samples stored
- ADDR_W, 16, sample memory address width; must satisfy 2^ADDR_W >= MAX_ELEMENTS*M*N

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; rewinds to sample 0 and latches num_samples
- num_samples  in  clog2(MAX_ELEMENTS+1)  samples in this pass; clamped to MAX_ELEMENTS
- data_request  in  1  request from distance calculator; rising edge triggers a fetch
- mem_rd_en  out  1  sample memory read strobe
- mem_addr  out  ADDR_W  element address = sample_idx*M*N + j
- mem_rdata  in  W  element data, valid 1 cycle after mem_rd_en
- type_rd_en  out  1  type memory read strobe
- type_addr  out  clog2(MAX_ELEMENTS)  type address = sample_idx
- type_rdata  in  TYPE_W  type data, valid 1 cycle after type_rd_en
- training_data  out  W x [0:(M*N)-1]  current sample vector
- training_data_type  out  TYPE_W  current sample type
- read_done  out  1  one-cycle pulse; sample vector valid
- sample_idx  out  clog2(MAX_ELEMENTS+1)  samples delivered since start
- all_loaded  out  1  level; set when a request arrives with sample_idx == num_samples

Behaviour:
- Reset values:
  - State IDLE.
  - mem_rd_en, type_rd_en, read_done, all_loaded = 0.
  - mem_addr, type_addr, sample_idx = 0.
  - training_data elements, training_data_type = 0.
  - Latched count = 0.
  - Previous-request register = 0.
- Reset mid-fetch aborts the fetch; no read_done is issued.
- Request detection:
  - req_rise = data_request & ~req_q, with req_q registered every cycle.
  - Only req_rise in IDLE is acted on.
  - Rises seen while in FETCH or DONE are dropped.
- States:
  - IDLE:
    - start: sample_idx <= 0, all_loaded <= 0, count <= min(num_samples, MAX_ELEMENTS).
    - req_rise with sample_idx < count: go to FETCH, j <= 0.
    - req_rise with sample_idx == count: all_loaded <= 1, stay in IDLE, no read_done.
    - start and req_rise in the same cycle: start wins, and the request is dropped.
  - FETCH:
    - Cycles 1..M*N after the request cycle (cycle 0): mem_rd_en = 1 and mem_addr = base + (c-1).
    - type_rd_en is high in cycle 1 only.
    - Element j is captured from mem_rdata into training_data[j] at the end of cycle j+2.
    - The type is captured at the end of cycle 2.
    - After the last capture (end of cycle M*N+1), go to DONE.
  - DONE:
    - read_done = 1 for exactly cycle M*N+2.
    - sample_idx increments at the end of that cycle.
    - Return to IDLE.
    - training_data holds stable until the next capture overwrites it.
- Latency: request cycle to read_done is M*N+2 cycles. The next fetch can start on a rise in cycle M*N+3 or later.
- start during FETCH or DONE is ignored.
- Address arithmetic:
  - base = sample_idx*M*N, computed at FETCH entry.
  - Truncate to ADDR_W.
  - No wrap-around beyond count; sample_idx saturates at count.
- num_samples = 0: the first request sets all_loaded immediately.

Optional Feature:
- Macro: TRAIN_LOADER_PREFETCH_EN.
- With the macro defined:
  - A shadow buffer (M*N x W plus type, with a valid flag) is added.
  - After each DONE, and after start, if the next sample exists the loader fetches it into the shadow with the same timing.
  - A req_rise with shadow valid copies the shadow to training_data and pulses read_done in cycle 1, then starts the next prefetch.
  - A req_rise while a prefetch is in flight is held pending and served as soon as the shadow becomes valid.
  - start invalidates the shadow.
- Without the macro: no shadow, and the behaviour is exactly as described above.

Test Plan:
- Single fetch (M=N=2, W=8, num_samples=3, mem[k]=k+1, type[s]=s+5): start, then raise data_request -> mem_addr 0..3 over 4 cycles; read_done in cycle 6; training_data={1,2,3,4}; type=5; sample_idx=1.
- Three sequential requests, each a separate rising edge -> vectors {1..4}, {5..8}, {9..12}, types 5, 6, 7; a 4th request gives no read_done and all_loaded=1.
- data_request held high for 20 cycles -> exactly one fetch and one read_done.
- Reset asserted in cycle 3 of a fetch -> no read_done; all outputs return to reset values; the next request fetches sample 0.
- start together with req_rise, and num_samples=0 -> request dropped; the next request sets all_loaded with no memory reads.
- TRAIN_LOADER_PREFETCH_EN defined: second request issued 10 cycles after the first read_done -> read_done in cycle 1; vector {5..8}.
